// File: rtl/cell_index_arbiter_pkg.sv
// Shared constants and FSM encoding for the pixel-to-cell converter.
package cell_index_arbiter_pkg;
  localparam int DEF_BLOCK_SIDE = 20;  // cell edge in pixels
  localparam int DEF_MAX_CELLS  = 20;  // cells per axis
  localparam int DEF_CW         = 10;  // pixel coordinate width
  localparam int DEF_IW         = 5;   // cell index width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/cell_div_step.sv
// One axis of the iterative divider: latches a raw coordinate, converts it to
// a zero-based remainder (with out-of-range detect), then strips BLOCK_SIDE
// per cycle while counting the quotient.
module cell_div_step
  import cell_index_arbiter_pkg::*;
#(
  parameter int BLOCK_SIDE = DEF_BLOCK_SIDE,
  parameter int MAX_CELLS  = DEF_MAX_CELLS,
  parameter int CW         = DEF_CW,
  parameter int IW         = DEF_IW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,   // capture raw coordinate
  input  logic [CW-1:0] d,
  input  logic          prep,   // raw -> (d-1), oor detect
  input  logic          step,   // one subtract iteration
  output logic [IW-1:0] q,
  output logic          done,   // remainder below one cell
  output logic          oor
);
  localparam logic [CW-1:0] LIM  = CW'(BLOCK_SIDE * MAX_CELLS);
  localparam logic [CW-1:0] BS   = CW'(BLOCK_SIDE);
  localparam logic [IW-1:0] QMAX = IW'(MAX_CELLS - 1);

  logic [CW-1:0] rem;

  // Load / prepare / subtract sequence for this axis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      q   <= '0;
      oor <= 1'b0;
    end else if (load) begin
      rem <= d;
      q   <= '0;
      oor <= 1'b0;
    end else if (prep) begin
      // 0 and out-of-range both collapse to index 0; exact multiples land
      // one cell lower because of the -1 bias.
      oor <= (rem > LIM);
      rem <= (rem == '0 || rem > LIM) ? '0 : rem - CW'(1);
    end else if (step && rem >= BS) begin
      rem <= rem - BS;
      if (q != QMAX) q <= q + IW'(1);
    end
  end

  assign done = (rem < BS);
endmodule

// File: rtl/cell_index_arbiter.sv
// Two-requester round-robin front end around a shared two-axis iterative
// pixel-to-cell divider.
module cell_index_arbiter
  import cell_index_arbiter_pkg::*;
#(
  parameter int BLOCK_SIDE = DEF_BLOCK_SIDE,
  parameter int MAX_CELLS  = DEF_MAX_CELLS,
  parameter int CW         = DEF_CW,
  parameter int IW         = DEF_IW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic          req1,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y1,
  output logic          ack0,
  output logic          ack1,
  output logic [IW-1:0] col,
  output logic [IW-1:0] row,
  output logic [1:0]    oor,
  output logic          busy
);
  state_t state, state_nxt;
  logic   grant, rr_last, gnt_sel, any_req;
  logic   ld, prep, step, all_done;

  logic [1:0][CW-1:0] d_in;   // [0]=x, [1]=y
  logic [1:0][IW-1:0] q;
  logic [1:0]         ax_done, ax_oor;

  assign any_req = req0 | req1;
  // Contention goes to whoever was not served last; otherwise the sole requester.
  assign gnt_sel = (req0 & req1) ? ~rr_last : req1;
  assign d_in[0] = gnt_sel ? x1 : x0;
  assign d_in[1] = gnt_sel ? y1 : y0;

  assign ld       = (state == IDLE) && any_req;
  assign prep     = (state == LOAD);
  assign all_done = &ax_done;
  assign step     = (state == RUN) && !all_done;

  for (genvar a = 0; a < 2; a++) begin : g_axis
    cell_div_step #(
      .BLOCK_SIDE(BLOCK_SIDE), .MAX_CELLS(MAX_CELLS), .CW(CW), .IW(IW)
    ) u_step (
      .clk  (clk),
      .rst_n(rst_n),
      .load (ld),
      .d    (d_in[a]),
      .prep (prep),
      .step (step),
      .q    (q[a]),
      .done (ax_done[a]),
      .oor  (ax_oor[a])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (all_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant   <= 1'b0;
      rr_last <= 1'b1;
      col     <= '0;
      row     <= '0;
      oor     <= '0;
    end else begin
      if (ld) begin
        grant   <= gnt_sel;
        rr_last <= gnt_sel;
      end
      if (state == RUN && all_done) begin
        col <= q[0];
        row <= q[1];
        oor <= ax_oor;   // {y,x}
      end
    end
  end

  assign ack0 = (state == DONE) && !grant;
  assign ack1 = (state == DONE) &&  grant;
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_cell_index_arbiter.sv
// Randomized + directed bench for cell_index_arbiter with a behavioural model.
module tb_cell_index_arbiter;
  logic       clk = 0, rst_n = 0;
  logic       req0 = 0, req1 = 0;
  logic [9:0] x0 = 0, y0 = 0, x1 = 0, y1 = 0;
  logic       ack0, ack1, busy;
  logic [4:0] col, row;
  logic [1:0] oor;

  int n_cmp = 0, n_bad = 0;

  cell_index_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .x0(x0), .y0(y0),
    .req1(req1), .x1(x1), .y1(y1),
    .ack0(ack0), .ack1(ack1), .col(col), .row(row), .oor(oor), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model of one axis: 0 -> 0, 1..400 -> ceil(d/20)-1, >400 -> 0 with flag.
  function automatic void ref_axis(input int d, output int q, output bit o);
    o = (d > 400);
    if (o || d == 0) q = 0;
    else             q = (d + 19) / 20 - 1;
  endfunction

  // Drives one request and reports what came back; comparisons are done by callers.
  task automatic run_op(input bit who, input logic [9:0] x, input logic [9:0] y,
                        input int drop_at, output bit got, output int lat,
                        output logic [4:0] c, output logic [4:0] r,
                        output logic [1:0] o, output bit other);
    got = 0; other = 0; lat = 0; c = 'x; r = 'x; o = 'x;
    @(negedge clk);
    if (who) begin req1 = 1; x1 = x; y1 = y; end
    else     begin req0 = 1; x0 = x; y0 = y; end
    @(posedge clk);
    while (!got && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (lat == drop_at) begin
        if (who) begin req1 = 0; x1 = ~x1; y1 = ~y1; end
        else     begin req0 = 0; x0 = ~x0; y0 = ~y0; end
      end
      if (who ? ack0 : ack1) other = 1;
      if (who ? ack1 : ack0) begin
        got = 1; c = col; r = row; o = oor;
        if (who) req1 = 0; else req0 = 0;
      end
    end
    if (!got) begin req0 = 0; req1 = 0; end
  endtask

  task automatic do_reset();
    rst_n = 0; req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    n_cmp++; if ({ack0, ack1, busy} !== 3'b000) begin n_bad++; $display("FAIL reset_ctrl got %b want 000", {ack0, ack1, busy}); end
    n_cmp++; if ({col, row, oor} !== 12'd0) begin n_bad++; $display("FAIL reset_data got col=%0d row=%0d oor=%b want 0", col, row, oor); end
    do_reset();
  endtask

  task automatic test_directed();
    bit got, oth; int lat; logic [4:0] c, r; logic [1:0] o;
    run_op(0, 10'd0, 10'd20, 0, got, lat, c, r, o, oth);
    n_cmp++; if (!got || lat !== 2) begin n_bad++; $display("FAIL dir1_lat got=%0d lat=%0d want 2", got, lat); end
    n_cmp++; if ({c, r, o} !== {5'd0, 5'd0, 2'b00}) begin n_bad++; $display("FAIL dir1_res col=%0d row=%0d oor=%b want 0 0 00", c, r, o); end
    run_op(0, 10'd21, 10'd400, 0, got, lat, c, r, o, oth);
    n_cmp++; if (!got || lat !== 21) begin n_bad++; $display("FAIL dir2_lat got=%0d lat=%0d want 21", got, lat); end
    n_cmp++; if ({c, r, o} !== {5'd1, 5'd19, 2'b00}) begin n_bad++; $display("FAIL dir2_res col=%0d row=%0d oor=%b want 1 19 00", c, r, o); end
    run_op(1, 10'd401, 10'd45, 0, got, lat, c, r, o, oth);
    n_cmp++; if (!got || lat !== 4 || oth) begin n_bad++; $display("FAIL dir3_lat got=%0d lat=%0d other=%0d want 4", got, lat, oth); end
    n_cmp++; if ({c, r, o} !== {5'd0, 5'd2, 2'b01}) begin n_bad++; $display("FAIL dir3_res col=%0d row=%0d oor=%b want 0 2 01", c, r, o); end
  endtask

  // Both requesters held together: order and results of the two grants.
  task automatic test_arbitration();
    int order[$]; logic [4:0] c1, r1; bit both; int cyc;
    do_reset();
    both = 0; c1 = 'x; r1 = 'x;
    @(negedge clk);
    req0 = 1; x0 = 10'd25; y0 = 10'd0;
    req1 = 1; x1 = 10'd0;  y1 = 10'd65;
    cyc = 0;
    while (order.size() < 2 && cyc < 80) begin
      @(negedge clk); cyc++;
      if (ack0 && ack1) both = 1;
      if (ack0) begin order.push_back(0); req0 = 0; end
      else if (ack1) begin order.push_back(1); req1 = 0; c1 = col; r1 = row; end
    end
    req0 = 0; req1 = 0;
    n_cmp++; if (order.size() != 2 || both) begin n_bad++; $display("FAIL arb_count got=%0d both=%0d want 2 0", order.size(), both); end
    n_cmp++; if (order.size() == 2 && (order[0] != 0 || order[1] != 1)) begin n_bad++; $display("FAIL arb_order got %0d,%0d want 0,1", order[0], order[1]); end
    n_cmp++; if ({c1, r1} !== {5'd0, 5'd3}) begin n_bad++; $display("FAIL arb_res1 col=%0d row=%0d want 0 3", c1, r1); end
    // second round: req1 was served last, so req0 must win again
    order.delete();
    @(negedge clk);
    req0 = 1; req1 = 1;
    cyc = 0;
    while (order.size() < 1 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (ack0) order.push_back(0);
      else if (ack1) order.push_back(1);
    end
    req0 = 0; req1 = 0;
    n_cmp++; if (order.size() != 1 || order[0] != 0) begin n_bad++; $display("FAIL arb_repeat got size=%0d first=%0d want ack0", order.size(), (order.size() > 0) ? order[0] : -1); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    bit got, oth, seen; int lat; logic [4:0] c, r; logic [1:0] o;
    run_op(0, 10'd100, 10'd60, 0, got, lat, c, r, o, oth);
    n_cmp++; if (!got || {c, r} !== {5'd4, 5'd2}) begin n_bad++; $display("FAIL abort_pre col=%0d row=%0d want 4 2", c, r); end
    @(negedge clk);
    req0 = 1; x0 = 10'd7; y0 = 10'd400;
    repeat (6) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy got %b want 1", busy); end
    rst_n = 0; req0 = 0;
    #1;
    n_cmp++; if ({ack0, ack1, busy, col, row, oor} !== 15'd0) begin n_bad++; $display("FAIL abort_out ack=%b%b busy=%b col=%0d row=%0d oor=%b want 0", ack0, ack1, busy, col, row, oor); end
    seen = 0;
    repeat (3) begin @(negedge clk); if (ack0 || ack1) seen = 1; end
    rst_n = 1;
    repeat (25) begin @(negedge clk); if (ack0 || ack1) seen = 1; end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL abort_noack saw ack want none"); end
    run_op(0, 10'd45, 10'd5, 0, got, lat, c, r, o, oth);
    n_cmp++; if (!got || lat !== 4 || {c, r, o} !== {5'd2, 5'd0, 2'b00}) begin n_bad++; $display("FAIL abort_after lat=%0d col=%0d row=%0d oor=%b want 4 2 0 00", lat, c, r, o); end
  endtask

  task automatic test_drop();
    bit got, oth, again; int lat; logic [4:0] c, r; logic [1:0] o;
    run_op(0, 10'd140, 10'd300, 3, got, lat, c, r, o, oth);
    n_cmp++; if (!got || lat !== 16) begin n_bad++; $display("FAIL drop_lat got=%0d lat=%0d want 16", got, lat); end
    n_cmp++; if ({c, r, o} !== {5'd6, 5'd14, 2'b00}) begin n_bad++; $display("FAIL drop_res col=%0d row=%0d oor=%b want 6 14 00", c, r, o); end
    again = 0;
    repeat (5) begin @(negedge clk); if (ack0 || ack1 || busy) again = 1; end
    n_cmp++; if (again) begin n_bad++; $display("FAIL drop_single extra activity after ack"); end
  endtask

  task automatic test_random();
    int bnd[9] = '{0, 1, 19, 20, 21, 399, 400, 401, 1023};
    bit got, oth, who, ox, oy; int lat, qx, qy, xi, yi, k;
    logic [4:0] c, r; logic [1:0] o;
    for (int i = 0; i < 40; i++) begin
      who = 1'($urandom_range(0, 1));
      xi = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 8)] : int'($urandom_range(0, 480));
      yi = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 8)] : int'($urandom_range(0, 480));
      ref_axis(xi, qx, ox);
      ref_axis(yi, qy, oy);
      k = (qx > qy) ? qx : qy;
      run_op(who, 10'(xi), 10'(yi), 0, got, lat, c, r, o, oth);
      n_cmp++;
      if (!got || oth || lat != k + 2 || c !== 5'(qx) || r !== 5'(qy) || o !== {oy, ox}) begin
        n_bad++;
        $display("FAIL rand%0d req%0d x=%0d y=%0d got=%0d other=%0d lat=%0d col=%0d row=%0d oor=%b want lat=%0d col=%0d row=%0d oor=%b",
                 i, who, xi, yi, got, oth, lat, c, r, o, k + 2, qx, qy, {oy, ox});
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_arbitration();
    test_reset_abort();
    test_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
